// File: rtl/universal_shift_reg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   WIDTH-bit universal shift register. Supports shift left/right with serial
//   fill, rotate left/right, and parallel load. A move counter (bit_cnt)
//   tracks the shift/rotate operations since the last load or reset, modulo
//   WIDTH. frame_done pulses for one cycle after the move that completes a
//   full frame of WIDTH moves.
//
// Ports:
//   clk          in   single clock, all state on rising edge
//   rst          in   synchronous active-high reset (beats every mode)
//   en           in   clock enable; en=0 holds shift_reg and bit_cnt
//   mode[2:0]    in   000 hold, 001 shl, 010 shr, 011 rol, 100 ror,
//                     101 load, 110/111 reserved (hold)
//   serial_in_l  in   bit entering bit 0 on shift left
//   serial_in_r  in   bit entering bit WIDTH-1 on shift right
//   par_in       in   parallel load data
//   shift_reg    out  registered contents
//   serial_out_l out  shift_reg[WIDTH-1]
//   serial_out_r out  shift_reg[0]
//   bit_cnt      out  moves since last load/reset, modulo WIDTH
//   frame_done   out  registered one-cycle pulse after the wrapping move
//
// Handshake: there is no valid/ready pair; every rising edge with en=1
// consumes mode and data inputs, and results appear on the outputs after
// that edge.
// ----------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] shift_reg,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_moved;
  logic             w_move;
  logic             w_load;
  logic             w_wrap;

  // Data path for the four move operations; other modes keep the contents.
  always_comb begin
    w_moved = r_shift;
    w_move  = 1'b0;
    case (mode)
      MODE_SHL: begin
        w_moved = {r_shift[WIDTH-2:0], serial_in_l};
        w_move  = 1'b1;
      end
      MODE_SHR: begin
        w_moved = {serial_in_r, r_shift[WIDTH-1:1]};
        w_move  = 1'b1;
      end
      MODE_ROL: begin
        w_moved = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
        w_move  = 1'b1;
      end
      MODE_ROR: begin
        w_moved = {r_shift[0], r_shift[WIDTH-1:1]};
        w_move  = 1'b1;
      end
      default: begin
        w_moved = r_shift;
        w_move  = 1'b0;
      end
    endcase
  end

  assign w_load = (mode == MODE_LOAD);
  // Compare against WIDTH-1 rather than relying on natural overflow so that
  // non-power-of-two widths still wrap every WIDTH moves.
  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (en && w_load) begin
      r_shift <= par_in;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (en && w_move) begin
      r_shift <= w_moved;
      r_cnt   <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_done  <= w_wrap;
    end else begin
      // Hold, reserved modes and en=0: contents and count stay, pulse ends.
      r_done  <= 1'b0;
    end
  end

  // MODE_HOLD is covered by the default branches above.
  logic w_unused_hold;
  assign w_unused_hold = (mode == MODE_HOLD);

  assign shift_reg    = r_shift;
  assign serial_out_l = r_shift[WIDTH-1];
  assign serial_out_r = r_shift[0];
  assign bit_cnt      = r_cnt;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Three instances (WIDTH 4, 8 and 2) share one stimulus stream. A behavioural
// model computes each instance's contents with integer arithmetic and the
// count of moves since the last load/reset; expected outputs are queued at
// the clock edge and popped by an independent monitor on the falling edge.
// ----------------------------------------------------------------------------
module tb_universal_shift_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       sil = 1'b0;
  logic       sir = 1'b0;
  logic [7:0] par = 8'h00;

  logic [3:0] sr4;  logic sol4, sor4;  logic [1:0] cnt4;  logic fd4;
  logic [7:0] sr8;  logic sol8, sor8;  logic [2:0] cnt8;  logic fd8;
  logic [1:0] sr2;  logic sol2, sor2;  logic [0:0] cnt2;  logic fd2;

  universal_shift_reg #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .serial_in_l(sil), .serial_in_r(sir), .par_in(par[3:0]),
    .shift_reg(sr4), .serial_out_l(sol4), .serial_out_r(sor4),
    .bit_cnt(cnt4), .frame_done(fd4)
  );

  universal_shift_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .serial_in_l(sil), .serial_in_r(sir), .par_in(par),
    .shift_reg(sr8), .serial_out_l(sol8), .serial_out_r(sor8),
    .bit_cnt(cnt8), .frame_done(fd8)
  );

  universal_shift_reg #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .serial_in_l(sil), .serial_in_r(sir), .par_in(par[1:0]),
    .shift_reg(sr2), .serial_out_l(sol2), .serial_out_r(sor2),
    .bit_cnt(cnt2), .frame_done(fd2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Packed expectation: {shift[7:0], cnt[2:0], frame_done}
  logic [11:0] exp4_q[$];
  logic [11:0] exp8_q[$];
  logic [11:0] exp2_q[$];

  int w_of[3] = '{4, 8, 2};
  int m_val[3];
  int m_moves[3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as an integer in [0, 2**w), and a plain count
  // of moves since the last load/reset.
  task automatic model_update(input int idx);
    int  w;
    int  full;
    int  half;
    int  v;
    logic mv;
    logic fd;
    logic [11:0] e;
    w    = w_of[idx];
    full = 1 << w;
    half = full / 2;
    v    = m_val[idx];
    mv   = 1'b0;
    fd   = 1'b0;
    if (rst) begin
      v = 0;
      m_moves[idx] = 0;
    end else if (en) begin
      case (mode)
        3'd1: begin v = (v * 2 + int'(sil)) % full;       mv = 1'b1; end
        3'd2: begin v = v / 2 + int'(sir) * half;         mv = 1'b1; end
        3'd3: begin v = (v * 2) % full + v / half;        mv = 1'b1; end
        3'd4: begin v = v / 2 + (v % 2) * half;           mv = 1'b1; end
        3'd5: begin v = int'(par) % full; m_moves[idx] = 0; end
        default: ;
      endcase
    end
    if (mv) begin
      m_moves[idx]++;
      fd = (m_moves[idx] % w == 0);
    end
    m_val[idx] = v;
    e = {8'(v), 3'(m_moves[idx] % w), fd};
    case (idx)
      0: exp4_q.push_back(e);
      1: exp8_q.push_back(e);
      default: exp2_q.push_back(e);
    endcase
  endtask

  task automatic compare(input string tag, input int w, input logic [11:0] e,
                         input int a_sr, input int a_cnt, input int a_fd,
                         input int a_sol, input int a_sor);
    int ev;
    ev = int'(e[11:4]);
    check({tag, ".shift_reg"},    a_sr,  ev);
    check({tag, ".bit_cnt"},      a_cnt, int'(e[3:1]));
    check({tag, ".frame_done"},   a_fd,  int'(e[0]));
    check({tag, ".serial_out_l"}, a_sol, (ev >> (w - 1)) & 1);
    check({tag, ".serial_out_r"}, a_sor, ev & 1);
  endtask

  // Monitor: the DUT presents a result after every edge; pop and compare.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp4_q.size() > 0) begin
      e = exp4_q.pop_front();
      compare("w4", 4, e, int'(sr4), int'(cnt4), int'(fd4), int'(sol4), int'(sor4));
    end
    if (exp8_q.size() > 0) begin
      e = exp8_q.pop_front();
      compare("w8", 8, e, int'(sr8), int'(cnt8), int'(fd8), int'(sol8), int'(sor8));
    end
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      compare("w2", 2, e, int'(sr2), int'(cnt2), int'(fd2), int'(sol2), int'(sor2));
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic sl, input logic sr, input logic [7:0] p);
    rst  = r;
    en   = e;
    mode = m;
    sil  = sl;
    sir  = sr;
    par  = p;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_update(i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int fd_count;
  logic [4:0] sl_seq;
  logic [4:0] sr_seq;

  initial begin
    @(negedge clk);

    // Shift left: 0,1,0,1,1 into width 4
    do_reset();
    check("rst.w4.shift_reg", int'(sr4), 0);
    check("rst.w8.bit_cnt", int'(cnt8), 0);
    sl_seq = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 3'b001, sl_seq[i], 1'b1, 8'hFF);
      if (i == 3) check("shl.fd_after_4th", int'(fd4), 1);
      if (i == 3) check("shl.cnt_after_4th", int'(cnt4), 0);
    end
    check("shl.w4.value", int'(sr4), 4'b1011);
    check("shl.w4.sol", int'(sol4), 1);
    check("shl.w4.cnt_after_5th", int'(cnt4), 1);
    check("shl.w4.fd_after_5th", int'(fd4), 0);

    // Shift right: 0,1,0,1,1 into width 4
    do_reset();
    sr_seq = 5'b11010;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b010, 1'b1, sr_seq[i], 8'hFF);
    check("shr.w4.value", int'(sr4), 4'b1101);
    check("shr.w4.sor", int'(sor4), 1);

    // Load 1001, rotate left x4, rotate right x1
    step(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 8'h09);
    check("load.w4.value", int'(sr4), 4'b1001);
    check("load.w4.cnt", int'(cnt4), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 8'h00);
    check("rol.w4.value", int'(sr4), 4'b1001);
    check("rol.w4.fd", int'(fd4), 1);
    step(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 8'h00);
    check("ror.w4.value", int'(sr4), 4'b1100);

    // Enable low with a move mode, then reserved mode with enable
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 3'b110, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 8'h00);
    check("hold.w4.value", int'(sr4), 4'b1100);
    check("hold.w4.cnt", int'(cnt4), 1);

    // Reset mid-frame on width 8, then a full frame
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 8'h00);
    do_reset();
    check("midrst.w8.shift_reg", int'(sr8), 0);
    check("midrst.w8.cnt", int'(cnt8), 0);
    check("midrst.w8.fd", int'(fd8), 0);
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 8'h00);
      if (fd8) fd_count++;
      if (i == 7) check("midrst.w8.fd_on_8th", int'(fd8), 1);
    end
    check("midrst.w8.fd_count", fd_count, 1);

    // Reset beats load
    step(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 8'hFF);
    check("rst_vs_load.w8", int'(sr8), 0);
    check("rst_vs_load.w4", int'(sr4), 0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    @(posedge clk);
    #1;
    check("drain.q4", exp4_q.size(), 0);
    check("drain.q8", exp8_q.size(), 0);
    check("drain.q2", exp2_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
